mem_tag_responder: RTL and testbench
====================================

Name: mem_tag_responder

Overview:
Memory-side responder for the tagged request/response protocol driven by the instruction and data cache front ends. It accepts at most one request per cycle and returns an accept pulse plus a nonzero transaction tag in the same cycle. Load data comes back tagged after a fixed latency, and the tag is recycled after return. It sits behind the memory arbiter and provides the current_req_tag, mem_data and mem_data_tag signals consumed by the cache MSHRs.

Parameters:
- LATENCY, 4, cycles from load acceptance to data return; must be >= 1.
- NUM_TAGS, 15, number of usable tags. Tags are 1..NUM_TAGS; tag 0 means "no transaction".
- MEM_LINES, 1024, number of 64-bit blocks in the backing array; must be a power of 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a request is presented this cycle.
- req_cmd  in  2  command: 0 = NONE, 1 = LOAD, 2 = STORE.
- req_addr  in  32  byte address; block index = req_addr[3 +: log2(MEM_LINES)]; all other bits are ignored.
- req_wdata  in  64  store data.
- req_accepted  out  1  request accepted this cycle (combinational).
- current_req_tag  out  4  tag assigned if a LOAD is accepted this cycle (combinational).
- mem_data  out  64  returned load block; 0 when no return.
- mem_data_tag  out  4  tag of the returned block; 0 when no return.
- outstanding  out  5  number of busy tags (registered).

Behaviour:
- Reset is synchronous and active-high on clock.
  - All tags are freed, the return pipeline is cleared, and mem_data, mem_data_tag and outstanding are 0.
  - Backing array contents are not reset.
  - Loads in flight at reset are dropped and never returned.
- Tag pool:
  - free_mask has NUM_TAGS bits.
  - current_req_tag is the lowest-numbered free tag, or 0 if no tag is free.
  - It is driven every cycle, independent of req_valid.
- Acceptance (combinational):
  - req_accepted = req_valid & ((cmd == LOAD & free tag exists) | cmd == STORE).
  - cmd == NONE is never accepted.
  - A rejected request has no side effects. The requester must hold or re-present it; there is no internal queue.
- LOAD accepted in cycle t:
  - The backing array is read with its state at cycle t.
  - The assigned tag becomes busy from cycle t+1.
  - The tag and data enter a LATENCY-deep shift pipeline.
  - During cycle t+LATENCY, mem_data and mem_data_tag are driven from a register.
  - The tag is freed at the end of cycle t+LATENCY and can be assigned again from cycle t+LATENCY+1.
- STORE accepted in cycle t:
  - req_wdata is written at the clock edge ending cycle t.
  - No tag is consumed and no response is returned.
  - A LOAD accepted in cycle t+1 or later sees the new data.
  - A LOAD accepted before cycle t+1 returns the old data even if its return happens after the store.
- Throughput:
  - The pipeline is fully pipelined: one accept per cycle and at most one return per cycle.
  - Returns are in acceptance order.
  - A return and a new accept in the same cycle are legal.
  - The tag being freed in cycle c is not reassignable in cycle c.
- Tag exhaustion: when all NUM_TAGS tags are busy, current_req_tag = 0 and LOADs are rejected; STOREs are still accepted.
- Address aliasing: block index bits wrap modulo MEM_LINES, and byte-offset bits [2:0] are ignored.
- outstanding: +1 on a LOAD accept, -1 on a return, net 0 if both occur in the same cycle. It never exceeds NUM_TAGS.

Test Plan:
1. STORE addr 0x40, data 0xDEADBEEF_01234567; then LOAD 0x40 in cycle t -> req_accepted = 1, current_req_tag = 1; in cycle t+4, mem_data_tag = 1 and mem_data = 0xDEADBEEF_01234567; both are 0 in all other cycles.
2. Back-to-back LOADs to 0x0, 0x8, 0x10 in cycles t..t+2 -> tags 1, 2, 3; returns in cycles t+4, t+5, t+6 in that order with matching data; outstanding peaks at 3 and is back to 0 at t+7.
3. With NUM_TAGS = 2 and LATENCY = 4, LOADs held valid for 6 cycles -> accepted at t and t+1 with tags 1, 2. Cycles t+2..t+4 show current_req_tag = 0 and req_accepted = 0. At t+5 tag 1 is reassigned and accepted.
4. While tags are exhausted (scenario 3 setup), present a STORE -> accepted; outstanding is unchanged.
5. Accept 3 LOADs, assert reset for 1 cycle at t+2 -> no nonzero mem_data_tag ever appears; outstanding = 0; the next LOAD gets tag 1; previously stored array data is intact.
6. Ordering and aliasing:
   - STORE 0x8 = A; LOAD 0x8 at t; STORE 0x8 = B at t+1 -> that load returns A.
   - A LOAD at t+2 returns B.
   - A LOAD to 0x8 + 8*MEM_LINES + 5 returns B (index wrap, offset ignored).

Source files
------------

// File: rtl/mem_tag_responder.sv
// Memory-side responder for the tagged cache request/response protocol.
// It accepts at most one LOAD or STORE per cycle. An accepted LOAD takes the
// lowest free nonzero tag, and its block is returned with that tag LATENCY
// cycles later. The tag is released at the end of the return cycle.
module mem_tag_responder #(
  parameter int LATENCY   = 4,
  parameter int NUM_TAGS  = 15,
  parameter int MEM_LINES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_accepted,
  output logic [3:0]  current_req_tag,
  output logic [63:0] mem_data,
  output logic [3:0]  mem_data_tag,
  output logic [4:0]  outstanding
);

  localparam int IDX_W = $clog2(MEM_LINES);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STORE = 2'd2
  } cmd_t;

  // Backing store; deliberately not reset so data survives a responder reset
  logic [63:0] mem_array [MEM_LINES];

  // Bit i set means tag i+1 is free
  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] free_next;

  // Return shift pipeline; an empty slot carries tag 0 and data 0
  logic [3:0]  pipe_tag  [LATENCY];
  logic [63:0] pipe_data [LATENCY];

  logic [IDX_W-1:0] line_idx;
  logic [3:0]       free_tag;
  logic             tag_available;
  logic             load_accept;
  logic             store_accept;
  logic             returning;
  logic             unused_addr_bits;

  // Only the block index selects a line; byte offset and high bits alias
  assign line_idx         = req_addr[3 +: IDX_W];
  assign unused_addr_bits = ^{req_addr[2:0], req_addr[31:3+IDX_W]};

  // Priority search for the lowest-numbered free tag, 0 when none is free
  always_comb begin
    free_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_tag = 4'(i + 1);
      end
    end
  end

  assign tag_available   = |free_mask;
  assign current_req_tag = free_tag;

  assign load_accept  = req_valid && (cmd_t'(req_cmd) == CMD_LOAD) && tag_available;
  assign store_accept = req_valid && (cmd_t'(req_cmd) == CMD_STORE);
  assign req_accepted = load_accept || store_accept;

  assign mem_data     = pipe_data[LATENCY-1];
  assign mem_data_tag = pipe_tag[LATENCY-1];
  assign returning    = (pipe_tag[LATENCY-1] != 4'd0);

  // Next free mask: release the returning tag and claim the newly assigned one.
  // The freed tag was not visible in free_tag this cycle, so the two never collide.
  always_comb begin
    free_next = free_mask;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (returning && (pipe_tag[LATENCY-1] == 4'(i + 1))) begin
        free_next[i] = 1'b1;
      end
      if (load_accept && (free_tag == 4'(i + 1))) begin
        free_next[i] = 1'b0;
      end
    end
  end

  // Tag pool register
  always_ff @(posedge clock) begin
    if (reset) begin
      free_mask <= '1;
    end else begin
      free_mask <= free_next;
    end
  end

  // Return pipeline: read the array at accept time, then shift toward the output
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag[i]  <= '0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_tag[0]  <= load_accept ? free_tag : 4'd0;
      pipe_data[0] <= load_accept ? mem_array[line_idx] : 64'd0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Count of busy tags; an accept and a return in the same cycle cancel
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
    end else if (load_accept && !returning) begin
      outstanding <= outstanding + 5'd1;
    end else if (!load_accept && returning) begin
      outstanding <= outstanding - 5'd1;
    end
  end

  // Store write at the end of the accept cycle; loads in that cycle see old data
  always_ff @(posedge clock) begin
    if (store_accept) begin
      mem_array[line_idx] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_tag_responder.sv
// Self-checking bench for mem_tag_responder. A default-parameter instance is
// checked against a reference model and a scoreboard of expected returns. A
// second instance with two tags exercises tag exhaustion from a fixed table.
module tb_mem_tag_responder;

  localparam int LAT   = 4;
  localparam int LINES = 1024;

  logic clock = 1'b0;
  logic reset;

  // Free-running clock
  always #5 clock = ~clock;

  logic        a_valid;
  logic [1:0]  a_cmd;
  logic [31:0] a_addr;
  logic [63:0] a_wdata;
  logic        a_acc;
  logic [3:0]  a_tag;
  logic [63:0] a_data;
  logic [3:0]  a_dtag;
  logic [4:0]  a_out;

  logic        b_valid;
  logic [1:0]  b_cmd;
  logic [31:0] b_addr;
  logic [63:0] b_wdata;
  logic        b_acc;
  logic [3:0]  b_tag;
  logic [63:0] b_data;
  logic [3:0]  b_dtag;
  logic [4:0]  b_out;

  mem_tag_responder #(.LATENCY(LAT), .NUM_TAGS(15), .MEM_LINES(LINES)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_valid), .req_cmd(a_cmd), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_accepted(a_acc), .current_req_tag(a_tag),
    .mem_data(a_data), .mem_data_tag(a_dtag), .outstanding(a_out)
  );

  mem_tag_responder #(.LATENCY(4), .NUM_TAGS(2), .MEM_LINES(LINES)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_valid), .req_cmd(b_cmd), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_accepted(b_acc), .current_req_tag(b_tag),
    .mem_data(b_data), .mem_data_tag(b_dtag), .outstanding(b_out)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        sb[$];
  logic [63:0] model_mem [int];
  logic [14:0] m_free;
  int          m_out;
  int          cyc;

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
    end
  endtask

  // One cycle on instance A: drive, check outputs against the model, advance the model
  task automatic applyStimulus(input logic valid, input logic [1:0] cmd,
                               input logic [31:0] addr, input logic [63:0] wdata,
                               input logic rst);
    logic [3:0]  exp_tag;
    logic        exp_acc;
    logic [3:0]  exp_dtag;
    logic [63:0] exp_data;
    int          idx;
    ret_t        r;
    a_valid = valid;
    a_cmd   = cmd;
    a_addr  = addr;
    a_wdata = wdata;
    reset   = rst;
    #1;
    exp_tag = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (m_free[i]) exp_tag = 4'(i + 1);
    end
    exp_acc  = valid && ((cmd == 2'd1 && exp_tag != 4'd0) || cmd == 2'd2);
    exp_dtag = 4'd0;
    exp_data = 64'd0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r        = sb.pop_front();
      exp_dtag = r.tag;
      exp_data = r.data;
    end
    if (!rst) begin
      checkOutput($sformatf("a_acc@%0d", cyc), a_acc, exp_acc);
      checkOutput($sformatf("a_tag@%0d", cyc), a_tag, exp_tag);
    end
    checkOutput($sformatf("a_dtag@%0d", cyc), a_dtag, exp_dtag);
    checkOutput($sformatf("a_data@%0d", cyc), a_data, exp_data);
    checkOutput($sformatf("a_out@%0d", cyc), a_out, m_out);
    idx = int'(addr[12:3]);
    if (rst) begin
      sb.delete();
      m_free = '1;
      m_out  = 0;
    end else begin
      if (exp_dtag != 4'd0) begin
        m_free[exp_dtag - 4'd1] = 1'b1;
        m_out--;
      end
      if (exp_acc && cmd == 2'd1) begin
        r.due  = cyc + LAT;
        r.tag  = exp_tag;
        r.data = model_mem.exists(idx) ? model_mem[idx] : 64'd0;
        sb.push_back(r);
        m_free[exp_tag - 4'd1] = 1'b0;
        m_out++;
      end
      if (exp_acc && cmd == 2'd2) begin
        model_mem[idx] = wdata;
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic idleA(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'd0, 64'd0, 1'b0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Exhaustion table for instance B: valid, cmd, accepted, tag, outstanding, return tag
  int bv [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int bc [12] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 0, 0, 0};
  int ba [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  int bt [12] = '{1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1};
  int bo [12] = '{0, 1, 2, 2, 2, 1, 1, 2, 2, 2, 1, 0};
  int br [12] = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0};

  // Main sequence
  initial begin
    reset   = 1'b1;
    a_valid = 1'b0; a_cmd = 2'd0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_cmd = 2'd0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Instance B: tag exhaustion, reassignment, stores while exhausted
    for (int k = 0; k < 12; k++) begin
      b_valid = bv[k][0];
      b_cmd   = 2'(bc[k]);
      b_addr  = 32'h100 + 32'(k * 8);
      b_wdata = 64'(k);
      #1;
      checkOutput($sformatf("b_acc@%0d", k), b_acc, 64'(ba[k]));
      checkOutput($sformatf("b_tag@%0d", k), b_tag, 64'(bt[k]));
      checkOutput($sformatf("b_out@%0d", k), b_out, 64'(bo[k]));
      checkOutput($sformatf("b_dtag@%0d", k), b_dtag, 64'(br[k]));
      @(posedge clock);
      @(negedge clock);
    end
    b_valid = 1'b0;

    // Instance A: model starts from the reset state
    m_free = '1;
    m_out  = 0;
    cyc    = 0;

    // Single store then load with a known pattern
    applyStimulus(1'b1, 2'd2, 32'h40, 64'hDEADBEEF_01234567, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h40, 64'd0, 1'b0);
    idleA(6);

    // Preload lines 0..7, then back-to-back loads
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'd2, 32'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 3), 1'b0);
    end
    applyStimulus(1'b1, 2'd1, 32'h0,  64'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h8,  64'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h10, 64'd0, 1'b0);
    idleA(6);

    // NONE is never accepted
    applyStimulus(1'b1, 2'd0, 32'h0, 64'd0, 1'b0);

    // Reset while three loads are in flight
    applyStimulus(1'b1, 2'd1, 32'h18, 64'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h20, 64'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h28, 64'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 32'h0,  64'd0, 1'b1);
    idleA(6);
    applyStimulus(1'b1, 2'd1, 32'h40, 64'd0, 1'b0);
    idleA(5);

    // Store/load ordering and address aliasing
    applyStimulus(1'b1, 2'd2, 32'h8, 64'h0000_0000_AAAA_AAAA, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h8, 64'd0, 1'b0);
    applyStimulus(1'b1, 2'd2, 32'h8, 64'h0000_0000_BBBB_BBBB, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h8, 64'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, 32'h8 + 32'(8 * LINES) + 32'd5, 64'd0, 1'b0);
    idleA(6);

    // Mixed traffic over the preloaded lines
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    32'($urandom_range(0, 7) * 8) | 32'($urandom_range(0, 7)),
                    {32'($urandom), 32'($urandom)}, 1'b0);
    end
    idleA(6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
